// File: rtl/dht11_poller.sv
// Periodic DHT11 acquisition sequencer: schedules start pulses, enforces the
// sensor's inter-read gap, retries failed/hung reads and holds the last good sample.
module dht11_poller #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int PERIOD_MS  = 2000,
    parameter int GAP_MS     = 1100,
    parameter int TIMEOUT_MS = 30,
    parameter int RETRY_MAX  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_force_read,
    output logic        o_dht_start,
    input  logic        i_dht_done,
    input  logic        i_dht_valid,
    input  logic [15:0] i_dht_humidity,
    input  logic [15:0] i_dht_temperature,
    output logic [15:0] o_humidity_out,
    output logic [15:0] o_temperature_out,
    output logic        o_data_valid,
    output logic        o_stale,
    output logic        o_update,
    output logic        o_fail,
    output logic [7:0]  o_err_count,
    output logic        o_busy,
    output logic [1:0]  o_state
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SINCE_W  = $clog2(PERIOD_MS + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_MS + 1);
    localparam int RETRY_W  = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [PRE_W-1:0]   TICK_L   = PRE_W'(TICK_DIV - 1);
    localparam logic [SINCE_W-1:0] PERIOD_L = SINCE_W'(PERIOD_MS);
    localparam logic [SINCE_W-1:0] GAP_L    = SINCE_W'(GAP_MS);
    localparam logic [TMO_W-1:0]   TMO_L    = TMO_W'(TIMEOUT_MS);
    localparam logic [RETRY_W-1:0] RETRY_L  = RETRY_W'(RETRY_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RETRY = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [PRE_W-1:0]     r_pre;
    logic [SINCE_W-1:0]   r_since;
    logic [TMO_W-1:0]     r_tmo;
    logic [RETRY_W-1:0]   r_retry;
    logic                 r_pend;
    logic                 r_start;
    logic                 r_busy;
    logic                 r_update;
    logic                 r_fail;
    logic                 r_data_valid;
    logic                 r_stale;
    logic [7:0]           r_err;
    logic [15:0]          r_hum;
    logic [15:0]          r_temp;

    logic w_tick;
    logic w_gap_ok;
    logic w_tmo_hit;
    logic w_succ;
    logic w_att_fail;
    logic w_ffail;

    assign w_tick    = (r_pre == TICK_L);
    assign w_gap_ok  = (r_since >= GAP_L);
    assign w_tmo_hit = w_tick && (r_tmo == TMO_L - TMO_W'(1));
    // A completion pulse in the same cycle as the timeout tick takes priority.
    assign w_succ     = (r_state == S_WAIT) && i_dht_done && i_dht_valid;
    assign w_att_fail = (r_state == S_WAIT) &&
                        ((i_dht_done && !i_dht_valid) || (!i_dht_done && w_tmo_hit));
    assign w_ffail    = w_att_fail && (r_retry >= RETRY_L);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gap_ok && (r_pend || (i_enable && r_since == PERIOD_L)))
                    w_next = S_START;
            end
            S_START: w_next = S_WAIT;
            S_WAIT: begin
                if (w_succ || w_ffail)
                    w_next = S_IDLE;
                else if (w_att_fail)
                    w_next = S_RETRY;
            end
            S_RETRY: begin
                if (w_gap_ok)
                    w_next = S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pre        <= '0;
            r_since      <= '0;
            r_tmo        <= '0;
            r_retry      <= '0;
            r_pend       <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_update     <= 1'b0;
            r_fail       <= 1'b0;
            r_data_valid <= 1'b0;
            r_stale      <= 1'b0;
            r_err        <= 8'd0;
            r_hum        <= 16'h0000;
            r_temp       <= 16'h0000;
        end else begin
            r_state  <= w_next;
            r_pre    <= w_tick ? '0 : r_pre + PRE_W'(1);
            r_pend   <= i_force_read || (r_pend && (w_next != S_START));
            r_start  <= (w_next == S_START);
            r_busy   <= (w_next != S_IDLE) || w_succ || w_ffail;
            r_update <= w_succ;
            r_fail   <= w_ffail;

            if (r_state == S_START)
                r_since <= '0;
            else if (w_tick && r_since != PERIOD_L)
                r_since <= r_since + SINCE_W'(1);

            if (r_state == S_START)
                r_tmo <= '0;
            else if (r_state == S_WAIT && w_tick && r_tmo != TMO_L)
                r_tmo <= r_tmo + TMO_W'(1);

            if (w_succ) begin
                r_hum        <= i_dht_humidity;
                r_temp       <= i_dht_temperature;
                r_data_valid <= 1'b1;
                r_stale      <= 1'b0;
                r_retry      <= '0;
            end

            if (w_att_fail) begin
                if (r_err != 8'hFF)
                    r_err <= r_err + 8'd1;
                if (w_ffail) begin
                    r_stale <= 1'b1;
                    r_retry <= '0;
                end else begin
                    r_retry <= r_retry + RETRY_W'(1);
                end
            end
        end
    end

    assign o_dht_start       = r_start;
    assign o_busy            = r_busy;
    assign o_update          = r_update;
    assign o_fail            = r_fail;
    assign o_data_valid      = r_data_valid;
    assign o_stale           = r_stale;
    assign o_err_count       = r_err;
    assign o_humidity_out    = r_hum;
    assign o_temperature_out = r_temp;
    assign o_state           = r_state;

endmodule

// File: tb/tb_dht11_poller.sv
// Directed bench for dht11_poller with a 100-cycle ms tick, period 5, gap 2,
// timeout 3, two retries; cycle offsets below are relative to the tick phase.
module tb_dht11_poller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        force_read;
    logic        dht_done;
    logic        dht_valid;
    logic [15:0] dht_h;
    logic [15:0] dht_t;
    logic        dht_start;
    logic [15:0] hum_out;
    logic [15:0] temp_out;
    logic        data_valid;
    logic        stale;
    logic        update;
    logic        fail;
    logic [7:0]  err_count;
    logic        busy;
    logic [1:0]  state;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    dht11_poller #(
        .CLK_HZ     (100_000),
        .PERIOD_MS  (5),
        .GAP_MS     (2),
        .TIMEOUT_MS (3),
        .RETRY_MAX  (2)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_enable          (enable),
        .i_force_read      (force_read),
        .o_dht_start       (dht_start),
        .i_dht_done        (dht_done),
        .i_dht_valid       (dht_valid),
        .i_dht_humidity    (dht_h),
        .i_dht_temperature (dht_t),
        .o_humidity_out    (hum_out),
        .o_temperature_out (temp_out),
        .o_data_valid      (data_valid),
        .o_stale           (stale),
        .o_update          (update),
        .o_fail            (fail),
        .o_err_count       (err_count),
        .o_busy            (busy),
        .o_state           (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    task automatic wait_start(input int budget, output int at, output bit seen);
        seen = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dht_start) begin
                seen = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    // Waits dly cycles, drives a one-cycle completion, returns in the cycle after.
    task automatic reply(input int dly, input logic v, input logic [15:0] h, input logic [15:0] t);
        repeat (dly) @(negedge clk);
        dht_done = 1'b1;
        dht_valid = v;
        dht_h = h;
        dht_t = t;
        @(negedge clk);
        dht_done = 1'b0;
        dht_valid = 1'b0;
        dht_h = 16'hdead;
        dht_t = 16'hbeef;
    endtask

    initial begin
        int  n0;
        int  at;
        int  s;
        int  f;
        bit  seen;

        rst = 1'b1;
        enable = 1'b0;
        force_read = 1'b0;
        dht_done = 1'b0;
        dht_valid = 1'b0;
        dht_h = 16'h0000;
        dht_t = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_start",  32'(dht_start), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_dv",     32'(data_valid), 32'd0);
        check("rst_hum",    32'(hum_out), 32'h0);
        check("rst_err",    32'(err_count), 32'd0);
        check("rst_state",  32'(state), 32'd0);

        // First scheduled read: since_cnt reaches PERIOD after 5 ticks.
        enable = 1'b1;
        rst = 1'b0;
        n0 = cyc;
        wait_start(700, at, seen);
        check("first_seen", 32'(seen), 32'd1);
        check("first_dly", 32'(at - n0), 32'd501);
        check("first_busy", 32'(busy), 32'd1);
        s = at;
        @(negedge clk);
        check("start_width", 32'(dht_start), 32'd0);
        reply(9, 1'b1, 16'h3200, 16'h1900);
        check("t1_update", 32'(update), 32'd1);
        check("t1_hum", 32'(hum_out), 32'h3200);
        check("t1_temp", 32'(temp_out), 32'h1900);
        check("t1_dv", 32'(data_valid), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_update_end", 32'(update), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Steady polling.
        for (int k = 0; k < 2; k++) begin
            wait_start(600, at, seen);
            check("poll_seen", 32'(seen), 32'd1);
            check("poll_spacing", 32'(at - s), 32'd500);
            s = at;
            reply(10, 1'b1, 16'h3300 + 16'(k), 16'h1a00 + 16'(k));
            check("poll_update", 32'(update), 32'd1);
            check("poll_hum", 32'(hum_out), 32'h3300 + 32'(k));
            check("poll_err", 32'(err_count), 32'd0);
        end

        // Bad checksum, then good retry two ticks later.
        wait_start(600, at, seen);
        check("t3_spacing", 32'(at - s), 32'd500);
        s = at;
        reply(10, 1'b0, 16'h1111, 16'h2222);
        check("t3_err", 32'(err_count), 32'd1);
        check("t3_nofail", 32'(fail), 32'd0);
        check("t3_noupd", 32'(update), 32'd0);
        check("t3_retry_state", 32'(state), 32'd3);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_hum_kept", 32'(hum_out), 32'h3301);
        wait_start(300, at, seen);
        check("t3_retry_dly", 32'(at - s), 32'd200);
        s = at;
        reply(5, 1'b1, 16'h4100, 16'h1a05);
        check("t3_update", 32'(update), 32'd1);
        check("t3_stale", 32'(stale), 32'd0);
        check("t3_err_kept", 32'(err_count), 32'd1);
        check("t3_hum", 32'(hum_out), 32'h4100);

        // No reply at all: three 3-tick timeouts; err goes 1 -> 4.
        wait_start(600, at, seen);
        check("t4_first", 32'(at - s), 32'd500);
        s = at;
        for (int k = 0; k < 2; k++) begin
            wait_start(400, at, seen);
            check("t4_retry_seen", 32'(seen), 32'd1);
            check("t4_retry_spacing", 32'(at - s), 32'd300);
            s = at;
        end
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fail) begin
                seen = 1'b1;
                at = cyc;
                break;
            end
        end
        check("t4_fail_seen", 32'(seen), 32'd1);
        check("t4_fail_dly", 32'(at - s), 32'd299);
        check("t4_stale", 32'(stale), 32'd1);
        check("t4_err", 32'(err_count), 32'd4);
        check("t4_hum_kept", 32'(hum_out), 32'h4100);
        check("t4_temp_kept", 32'(temp_out), 32'h1a05);
        check("t4_dv_kept", 32'(data_valid), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t4_fail_end", 32'(fail), 32'd0);
        check("t4_busy_end", 32'(busy), 32'd0);

        // Forced reads with scheduling disabled.
        enable = 1'b0;
        repeat (298) @(negedge clk);
        force_read = 1'b1;
        f = cyc;
        @(negedge clk);
        force_read = 1'b0;
        wait_start(50, at, seen);
        check("t5_force_dly", 32'(at - f), 32'd2);
        s = at;
        reply(5, 1'b1, 16'h5511, 16'h2233);
        check("t5_update", 32'(update), 32'd1);
        check("t5_stale_clr", 32'(stale), 32'd0);
        repeat (114) @(negedge clk);
        force_read = 1'b1;
        @(negedge clk);
        force_read = 1'b0;
        wait_start(300, at, seen);
        check("t5_gap_defer", 32'(at - s), 32'd200);
        s = at;
        repeat (3) @(negedge clk);
        force_read = 1'b1;
        @(negedge clk);
        force_read = 1'b0;
        reply(6, 1'b1, 16'h6622, 16'h3344);
        check("t5_busy_upd", 32'(update), 32'd1);
        check("t5_busy_hum", 32'(hum_out), 32'h6622);
        wait_start(300, at, seen);
        check("t5_pend_start", 32'(at - s), 32'd200);
        reply(5, 1'b1, 16'h7733, 16'h4455);
        check("t5_last_temp", 32'(temp_out), 32'h4455);
        wait_start(800, at, seen);
        check("t5_no_extra", 32'(seen), 32'd0);

        // Reset during WAIT; a late done must be ignored.
        force_read = 1'b1;
        f = cyc;
        @(negedge clk);
        force_read = 1'b0;
        wait_start(50, at, seen);
        check("t6_start", 32'(at - f), 32'd2);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_start", 32'(dht_start), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_hum", 32'(hum_out), 32'h0);
        check("t6_rst_temp", 32'(temp_out), 32'h0);
        check("t6_rst_dv", 32'(data_valid), 32'd0);
        check("t6_rst_stale", 32'(stale), 32'd0);
        check("t6_rst_err", 32'(err_count), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        force_read = 1'b1;
        n0 = cyc;
        @(negedge clk);
        force_read = 1'b0;
        dht_done = 1'b1;
        dht_valid = 1'b1;
        dht_h = 16'h7777;
        dht_t = 16'h7777;
        @(negedge clk);
        dht_done = 1'b0;
        dht_valid = 1'b0;
        check("t6_late_noupd", 32'(update), 32'd0);
        check("t6_late_hum", 32'(hum_out), 32'h0);
        check("t6_late_dv", 32'(data_valid), 32'd0);

        // Forced read after reset waits for the power-up gap; done on the timeout tick wins.
        wait_start(300, at, seen);
        check("t7_start_dly", 32'(at - n0), 32'd201);
        s = at;
        reply(298, 1'b1, 16'h2a00, 16'h1500);
        check("t7_update", 32'(update), 32'd1);
        check("t7_nofail", 32'(fail), 32'd0);
        check("t7_err", 32'(err_count), 32'd0);
        check("t7_hum", 32'(hum_out), 32'h2a00);
        check("t7_temp", 32'(temp_out), 32'h1500);
        check("t7_dv", 32'(data_valid), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
